// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and single-issue sequencer in front of the clocked sign-magnitude ALU.
// Traps illegal opcodes locally and returns results in acceptance order.
module alu_cmd_sequencer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ALU_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [4:0]  cmd_op,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [4:0]  ALU_CONTROL,
   input  logic [31:0] alu_y,
   input  logic        alu_z,
   input  logic        alu_v,
   input  logic        alu_n,
   input  logic        alu_c,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_y,
   output logic [3:0]  res_flags,
   output logic [4:0]  res_op,
   output logic        res_err,
   output logic        busy
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CntW-1:0] CntInit = CntW'(ALU_LAT - 1);
   localparam logic [PtrW:0]   CountFull = (PtrW + 1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

   state_e state_q, state_d;

   logic [4:0]  mem_op_q [DEPTH];
   logic [31:0] mem_a_q  [DEPTH];
   logic [31:0] mem_b_q  [DEPTH];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]   count_q, count_d;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     a_q, a_d, b_q, b_d;
   logic [4:0]      ctl_q, ctl_d;
   logic [31:0]     res_y_q, res_y_d;
   logic [3:0]      res_flags_q, res_flags_d;
   logic [4:0]      res_op_q, res_op_d;
   logic            res_err_q, res_err_d;
   logic            res_valid_q, res_valid_d;

   logic        empty, full, push, pop, head_legal;
   logic [4:0]  head_op;
   logic [31:0] head_a, head_b;

   function automatic logic op_legal(input logic [4:0] op);
      logic ok;
      case (op[4:3])
         2'b00:   ok = (op[2] == 1'b0);
         2'b01:   ok = (op[2:0] <= 3'd5);
         2'b10:   ok = (op[2:0] <= 3'd2);
         default: ok = (op[2] == 1'b0);
      endcase
      return ok;
   endfunction

   assign empty      = (count_q == '0);
   assign full       = (count_q == CountFull);
   assign cmd_ready  = !full && !rst;
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state_q == StIdle) && !empty;
   assign head_op    = mem_op_q[rd_ptr_q];
   assign head_a     = mem_a_q[rd_ptr_q];
   assign head_b     = mem_b_q[rd_ptr_q];
   assign head_legal = op_legal(head_op);

   // FIFO storage carries no reset; occupancy alone defines validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_op_q[wr_ptr_q] <= cmd_op;
         mem_a_q[wr_ptr_q]  <= cmd_a;
         mem_b_q[wr_ptr_q]  <= cmd_b;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (PtrW + 1)'(1);
         2'b01:   count_d = count_q - (PtrW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!empty) state_d = head_legal ? StWait : StHold;
         StWait:  if (cnt_q == '0) state_d = StHold;
         StHold:  if (res_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      ctl_d       = ctl_q;
      res_y_d     = res_y_q;
      res_flags_d = res_flags_q;
      res_op_d    = res_op_q;
      res_err_d   = res_err_q;
      res_valid_d = res_valid_q;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               if (head_legal) begin
                  a_d   = head_a;
                  b_d   = head_b;
                  ctl_d = head_op;
                  cnt_d = CntInit;
               end else begin
                  // Trapped: the ALU never sees this opcode.
                  res_y_d     = '0;
                  res_flags_d = '0;
                  res_err_d   = 1'b1;
                  res_op_d    = head_op;
                  res_valid_d = 1'b1;
               end
            end
         end
         StWait: begin
            if (cnt_q == '0) begin
               res_y_d     = alu_y;
               res_flags_d = {alu_z, alu_v, alu_n, alu_c};
               res_err_d   = 1'b0;
               res_op_d    = ctl_q;
               res_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StHold: begin
            if (res_ready) res_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         ctl_q       <= '0;
         res_y_q     <= '0;
         res_flags_q <= '0;
         res_op_q    <= '0;
         res_err_q   <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         ctl_q       <= ctl_d;
         res_y_q     <= res_y_d;
         res_flags_q <= res_flags_d;
         res_op_q    <= res_op_d;
         res_err_q   <= res_err_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign A           = a_q;
   assign B           = b_q;
   assign ALU_CONTROL = ctl_q;
   assign res_y       = res_y_q;
   assign res_flags   = res_flags_q;
   assign res_op      = res_op_q;
   assign res_err     = res_err_q;
   assign res_valid   = res_valid_q;
   assign busy        = !empty || (state_q != StIdle);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural clocked ALU alongside it.
module tb_alu_cmd_sequencer;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned ALU_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [4:0]  cmd_op = '0;
   logic [31:0] cmd_a = '0, cmd_b = '0;
   logic [31:0] A, B;
   logic [4:0]  ALU_CONTROL;
   logic [31:0] alu_y = '0;
   logic        alu_z = 1'b0, alu_v = 1'b0, alu_n = 1'b0, alu_c = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] res_y;
   logic [3:0]  res_flags;
   logic [4:0]  res_op;
   logic        res_err;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [41:0] exp_q[$];  // {op, err, y, flags}
   bit done_rand;

   logic [4:0] legal_ops [17] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
                                  5'd13, 5'd16, 5'd17, 5'd18, 5'd24, 5'd25, 5'd26, 5'd27};

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .A(A), .B(B), .ALU_CONTROL(ALU_CONTROL), .alu_y(alu_y),
      .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n), .alu_c(alu_c), .res_valid(res_valid),
      .res_ready(res_ready), .res_y(res_y), .res_flags(res_flags), .res_op(res_op),
      .res_err(res_err), .busy(busy)
   );

   // Sign-magnitude ALU semantics; returns {y, z, v, n, c}.
   function automatic logic [35:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, r, mag;
      logic [31:0] y;
      logic [30:0] q, rm;
      logic v, c;
      int sh;
      sa = longint'({33'd0, a[30:0]});
      sb = longint'({33'd0, b[30:0]});
      if (a[31]) sa = -sa;
      if (b[31]) sb = -sb;
      y = '0; v = 1'b0; c = 1'b0; r = 0; sh = int'(b[4:0]);
      case (op)
         5'd0, 5'd1, 5'd2: begin
            if (op == 5'd0) r = sa + sb;
            else if (op == 5'd1) r = sa - sb;
            else r = sa * sb;
            mag = (r < 0) ? -r : r;
            if (mag > 64'd2147483647) v = 1'b1;
            y = {r < 0, mag[30:0]};
         end
         5'd3: begin
            if (b[30:0] == '0) v = 1'b1;
            else begin
               q  = a[30:0] / b[30:0];
               rm = a[30:0] % b[30:0];
               y  = {rm[15:0], q[15:0]};
            end
         end
         5'd8:  y = a & b;
         5'd9:  y = a | b;
         5'd10: y = a ^ b;
         5'd11: y = ~(a | b);
         5'd12: y = ~(a & b);
         5'd13: y = ~(a ^ b);
         5'd16: y = {31'd0, sa == sb};
         5'd17: y = {31'd0, sa < sb};
         5'd18: y = {31'd0, sa > sb};
         5'd24: begin
            y = a << sh;
            if (sh != 0) c = a[32-sh];
         end
         5'd25: y = a >> sh;
         5'd26: y = 32'($signed(a) >>> sh);
         5'd27: for (int i = 0; i < 32; i++) y[i] = a[31-i];
         default: y = '0;
      endcase
      return {y, y == 32'd0, v, y[31], c};
   endfunction

   function automatic bit is_legal(input logic [4:0] op);
      return op inside {[5'd0:5'd3], [5'd8:5'd13], [5'd16:5'd18], [5'd24:5'd27]};
   endfunction

   // One register stage: output reflects operands ALU_LAT-1 edges after issue.
   always_ff @(posedge clk) begin
      {alu_y, alu_z, alu_v, alu_n, alu_c} <= alu_ref(ALU_CONTROL, A, B);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic exp_push(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [35:0] r;
      r = alu_ref(op, a, b);
      if (is_legal(op)) exp_q.push_back({op, 1'b0, r[35:4], r[3:0]});
      else              exp_q.push_back({op, 1'b1, 32'd0, 4'd0});
   endtask

   task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      int tries;
      bit done;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      tries = 0; done = 0;
      while (!done) begin
         @(negedge clk);
         if (cmd_ready) begin
            exp_push(op, a, b);
            done = 1;
         end
         @(posedge clk); #1;
         tries++;
         if (!done && tries > 300) begin
            check("send_timeout", 64'(tries), 64'd0);
            done = 1;
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic offer(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int acc);
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      @(negedge clk);
      acc = cmd_ready ? 1 : 0;
      if (cmd_ready) exp_push(op, a, b);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!res_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!res_valid) check("wait_valid_timeout", 64'(res_valid), 64'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || res_valid || exp_q.size() != 0) && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_idle", {31'd0, busy, 32'(exp_q.size())}, 64'd0);
   endtask

   // Monitor: a handshake seen before the edge retires the oldest expected result.
   initial begin
      logic [41:0] e;
      forever begin
         @(negedge clk);
         if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_result: got op=%b y=%h, required no result", res_op,
                        res_y);
            end else begin
               e = exp_q.pop_front();
               check("result", 64'({res_op, res_err, res_y, res_flags}), 64'(e));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1);
   end

   initial begin
      logic [4:0]  op, prev_ctl;
      logic [31:0] prev_a;
      logic [31:0] snap_y;
      logic [3:0]  snap_f;
      logic [68:0] snap_alu;
      int acc, total;
      logic [4:0]  f_op [7] = '{5'd1, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11, 5'd24};
      logic [31:0] f_a  [7] = '{32'd82, 32'd23, 32'hF0F0_1234, 32'h0F00_0001, 32'hFFFF_0000,
                                32'h1234_5678, 32'h0000_0F0F};
      logic [31:0] f_b  [7] = '{32'd32, 32'd6, 32'h0FF0_FF00, 32'h00F0_0010, 32'h0F0F_0F0F,
                                32'h0000_FFFF, 32'd4};

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_alu_regs", {A, B}, 64'd0);
      check("rst_res", 64'({ALU_CONTROL, res_y, res_flags, res_op, res_err, res_valid, busy}),
            64'd0);
      check("rst_cmd_ready_low", 64'(cmd_ready), 64'd0);
      rst = 1'b0;
      #1 check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

      // Single add with exact latency
      send(5'd0, 32'h8000_0010, 32'h0000_0004);
      @(posedge clk); #1;
      check("add_issue_ab", {A, B}, {32'h8000_0010, 32'h0000_0004});
      check("add_issue_ctl", 64'(ALU_CONTROL), 64'd0);
      check("add_not_early1", 64'(res_valid), 64'd0);
      @(posedge clk); #1;
      check("add_not_early2", 64'(res_valid), 64'd0);
      @(posedge clk); #1;
      check("add_valid", 64'(res_valid), 64'd1);
      check("add_fields", 64'({res_y, res_flags, res_err, res_op}),
            64'({32'h8000_000C, 4'b0010, 1'b0, 5'd0}));
      wait_idle();

      // Illegal opcode trapped
      prev_ctl = ALU_CONTROL;
      prev_a   = A;
      send(5'b00100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      check("ill_valid", 64'(res_valid), 64'd1);
      check("ill_fields", 64'({res_err, res_y, res_flags, res_op}),
            64'({1'b1, 32'd0, 4'd0, 5'b00100}));
      check("ill_alu_kept", 64'({ALU_CONTROL, A}), 64'({prev_ctl, prev_a}));
      wait_idle();

      // Backpressure and fill
      res_ready = 1'b0;
      total = 0;
      for (int i = 0; i < 7; i++) begin
         offer(f_op[i], f_a[i], f_b[i], acc);
         total += acc;
      end
      check("fill_accepted", 64'(total), 64'd5);
      check("fill_ready_low", 64'(cmd_ready), 64'd0);
      check("fill_first_result", 64'(res_y), 64'h0000_0032);
      res_ready = 1'b1;
      @(posedge clk); #1;
      check("fill_ready_low_after_release", 64'(cmd_ready), 64'd0);
      check("fill_second_result", 64'(res_valid), 64'd0);
      @(posedge clk); #1;
      check("fill_ready_rise", 64'(cmd_ready), 64'd1);
      wait_idle();

      // Stall with a queued command behind it
      res_ready = 1'b0;
      send(5'd25, 32'hA000_0068, 32'd3);
      send(5'd0, 32'd1, 32'd2);
      wait_valid();
      check("stall_lsr_y", 64'(res_y), 64'h1400_000D);
      snap_y = res_y; snap_f = res_flags; snap_alu = {A, B, ALU_CONTROL};
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("stall_stable", 64'({res_valid, res_y, res_flags}), 64'({1'b1, snap_y, snap_f}));
         check("stall_no_issue", snap_alu[63:0], {A[26:0], B, ALU_CONTROL});
      end
      res_ready = 1'b1;
      wait_idle();

      // Reset in WAIT with two commands queued
      res_ready = 1'b0;
      send(5'd9, 32'h1, 32'h2);
      send(5'd2, 32'd7, 32'd9);
      send(5'd1, 32'd5, 32'd3);
      send(5'd8, 32'hFF, 32'h0F);
      wait_valid();
      res_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_wait_issued", 64'(ALU_CONTROL), 64'd2);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      check("rst2_alu_regs", {A, B}, 64'd0);
      check("rst2_res", 64'({ALU_CONTROL, res_y, res_flags, res_op, res_err, res_valid, busy}),
            64'd0);
      check("rst2_cmd_ready_low", 64'(cmd_ready), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst2_cmd_ready_high", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         check("rst2_quiet", 64'({res_valid, busy}), 64'd0);
         @(posedge clk); #1;
      end
      send(5'd27, 32'h8000_00C6, 32'd0);
      wait_valid();
      check("rev_y", 64'(res_y), 64'h6300_0001);
      wait_idle();

      // Wrap-around: 2*DEPTH+1 commands through the pointers
      send(5'd26, 32'h8000_05EA, 32'd8);
      for (int i = 0; i < 2 * DEPTH; i++) begin
         send(legal_ops[$urandom_range(16)], $urandom, $urandom);
      end
      wait_idle();

      // Randomized traffic with random consumer backpressure
      done_rand = 0;
      fork
         begin
            for (int i = 0; i < 160; i++) begin
               if ($urandom_range(7) == 0) op = 5'($urandom);
               else op = legal_ops[$urandom_range(16)];
               send(op, $urandom, ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(40)));
            end
            done_rand = 1;
         end
         begin
            while (!done_rand) begin
               res_ready = ($urandom_range(3) != 0);
               @(posedge clk); #1;
            end
            res_ready = 1'b1;
         end
      join
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream command stage for the sign-magnitude ALU. It accepts (opcode, A, B) commands on a valid/ready interface and buffers them in a small FIFO. It issues one command at a time to the clocked ALU's `A`/`B`/`ALU_CONTROL` inputs, waits a fixed ALU latency, then captures `Y` and the Z/V/N/C flags into a result register on a second valid/ready interface. Illegal opcodes are trapped here and are never presented to the ALU.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `ALU_LAT`, 2: clock edges from issuing operands to sampling `alu_y` and the flags (≥1).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept.
- `cmd_op` in 5: ALU opcode.
- `cmd_a`, `cmd_b` in 32: operands.
- `A`, `B` out 32: registered operands to the ALU.
- `ALU_CONTROL` out 5: registered opcode to the ALU.
- `alu_y` in 32: ALU result.
- `alu_z`, `alu_v`, `alu_n`, `alu_c` in 1: ALU flags.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts.
- `res_y` out 32: captured result.
- `res_flags` out 4: {Z,V,N,C}.
- `res_op` out 5: opcode of this result.
- `res_err` out 1: illegal opcode.
- `busy` out 1: FIFO non-empty or state ≠ IDLE.

## Operation
- Legal opcodes:
  - 00000–00011 (add, sub, mul, div)
  - 01000–01101 (and, or, xor, nor, nand, xnor)
  - 10000–10010 (eq, lt, gt)
  - 11000–11011 (lsl, lsr, asr, rev)
- All other opcodes are illegal.
- Push: on an edge with `cmd_valid && cmd_ready`, write {op,a,b} at the tail. `cmd_ready = !full && !rst`.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head.
    - Legal opcode: load `A`, `B`, `ALU_CONTROL`, set cnt = ALU_LAT-1, go to WAIT.
    - Illegal opcode: leave the ALU outputs unchanged; set `res_y`=0, `res_flags`=0, `res_err`=1, `res_op`=op, `res_valid`=1; go to HOLD.
  - WAIT: if cnt==0, capture `alu_y`→`res_y`, {z,v,n,c}→`res_flags`, `res_err`=0, `res_op`=`ALU_CONTROL`, `res_valid`=1, go to HOLD. Otherwise decrement cnt.
  - HOLD: on `res_valid && res_ready`, clear `res_valid` and go to IDLE. No issue happens in the same edge.
- One command in flight. Results are returned strictly in acceptance order.
- `A`, `B` and `ALU_CONTROL` hold their last issued values until the next legal issue.
- Result fields are stable while `res_valid` is high and `res_ready` is low.
- The FIFO uses an occupancy counter of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.

## Timing
- Reset (any state, any cycle): on the edge with `rst`=1:
  - state goes to IDLE; FIFO is emptied; cnt is cleared.
  - `A`, `B`, `ALU_CONTROL`, `res_y`, `res_flags`, `res_op`, `res_err`, `res_valid` all go to 0; `busy`=0.
  - `cmd_ready`=0 while `rst` is high and 1 in the first cycle after.
  - In-flight and queued commands are discarded; no result is produced for them.
- Legal latency: push at edge k, issue at edge k+1, capture at edge k+1+ALU_LAT. `res_valid` is visible after that edge (3 cycles after push with ALU_LAT=2).
- Illegal latency: push at edge k, `res_valid` visible after edge k+1.
- Peak throughput: one legal result per ALU_LAT+2 cycles with `res_ready` held high.
- Full FIFO: `cmd_ready` is 0, so a push attempted on the same edge as a pop is not accepted. Capacity is DEPTH queued plus 1 in flight.
- Push into an empty FIFO while in IDLE: the entry is issued on the following edge. There is no bypass.

## Test plan
- Single add: A=0x80000010, B=0x00000004, op=00000, `res_ready`=1. Expect `res_valid` 3 cycles after push, `res_y`=0x8000000C, `res_flags`=0010 (N=1), `res_err`=0, `res_op`=00000. `A`/`B`/`ALU_CONTROL` equal the command from edge k+1.
- Backpressure/fill (DEPTH=4): hold `res_ready`=0 and offer 7 commands back-to-back (sub 82−32, div 23/6, and, or, xor, nor, lsl).
  - Exactly 5 are accepted; `cmd_ready` stays low afterwards.
  - Raise `res_ready`. Results arrive in order: 0x00000032, 0x00050003, …
  - `cmd_ready` rises one cycle after the first pop that frees a slot.
- Illegal op 00100 with A=B=0xFFFFFFFF: `res_valid` after edge k+1 with `res_err`=1, `res_y`=0, `res_flags`=0, `res_op`=00100. `ALU_CONTROL` keeps its prior value.
- Stall: hold `res_ready`=0 for 10 cycles on an lsr result (0x1400000D). `res_y`, `res_flags` and the ALU outputs stay constant, and the next queued command is not issued.
- Reset in WAIT: assert `rst` one cycle after issue with 2 commands queued. After reset: all outputs 0, `busy`=0, no `res_valid` pulse, `cmd_ready`=1 the next cycle, and a fresh rev command (A=0x800000C6) returns 0x63000001.
- Wrap-around: push and drain 2·DEPTH+1 commands (asr 0x800005EA>>8 → 0xFF800005 among them). Every result matches in order; no duplicates or losses across pointer wrap.
